// File: rtl/clint_vec_pkg.sv
// Shared types and constants for the clint_vec core-local interrupt controller.
// Contents: FSM state and arbitration enums, SYSTEM instruction encodings,
// CSR addresses, mtvec mode encodings, cause codes and mstatus update helpers.
package clint_vec_pkg;

  // Source index width; covers up to 16 sources.
  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_MEPC         = 3'd1,
    ST_MSTATUS      = 3'd2,
    ST_MCAUSE       = 3'd3,
    ST_ASSERT       = 3'd4,
    ST_MRET_MSTATUS = 3'd5,
    ST_MRET_ASSERT  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ARB_NONE  = 2'd0,
    ARB_SYNC  = 2'd1,
    ARB_ASYNC = 2'd2,
    ARB_MRET  = 2'd3
  } arb_e;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [1:0] INT_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] INT_MODE_VECTORED = 2'b01;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [30:0] CAUSE_MTIMER = 31'd7;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
    return {s[31:8], s[3], s[6:4], 1'b0, s[2:0]};
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] s);
    return {s[31:8], 1'b1, s[6:4], s[7], s[2:0]};
  endfunction

  function automatic logic [31:0] csr_waddr(input logic [11:0] a);
    return {20'h0_0000, a};
  endfunction

endpackage

// File: rtl/clint_vec_if.sv
// Trap-side bus of clint_vec: pipeline hold, CSR write port and ex redirect.
// master: driven by clint_vec.  slave: seen by ctrl / csr_reg / ex.
//   hold_flag_o  pipeline hold request
//   we_o         CSR write enable
//   waddr_o      CSR write address
//   data_o       CSR write data
//   int_addr_o   redirect target
//   int_assert_o one-cycle redirect pulse
interface clint_vec_if;
  logic        hold_flag_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic [31:0] int_addr_o;
  logic        int_assert_o;

  modport master (
    output hold_flag_o, we_o, waddr_o, data_o, int_addr_o, int_assert_o
  );

  modport slave (
    input hold_flag_o, we_o, waddr_o, data_o, int_addr_o, int_assert_o
  );
endinterface

// File: rtl/clint_vec_irq_prio_enc.sv
// Masked lowest-index-wins priority encoder for interrupt sources.
// Ports:
//   req_i    NUM_IRQ  level requests
//   en_i     NUM_IRQ  per-source enable mask
//   valid_o  1        any enabled request present
//   idx_o    IDX_W    index of the winning source
//   onehot_o NUM_IRQ  one-hot of the winning source
module clint_vec_irq_prio_enc
  import clint_vec_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req_i,
  input  logic [NUM_IRQ-1:0] en_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [NUM_IRQ-1:0] onehot_o
);

  logic [NUM_IRQ-1:0] masked_s;

  assign masked_s = req_i & en_i;
  assign valid_o  = |masked_s;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = masked_s & (~masked_s + NUM_IRQ'(1));

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx_o = masked_s[i] ? IDX_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/clint_vec.sv
// Core-local interrupt controller with per-source masking, fixed priority and
// vectored mtvec. Runs MEPC -> MSTATUS -> MCAUSE writes then redirects ex.
// Ports:
//   clk, rst (async, active-low)
//   irq_i / irq_en_i          level requests and enable mask
//   inst_i / inst_addr_i      instruction in id and its address
//   jump_flag_i / jump_addr_i ex redirect in flight
//   div_started_i             divider busy
//   csr_mtvec / csr_mepc / csr_mstatus / global_int_en_i  CSR images
//   bus                       hold, CSR write port, redirect (clint_vec_if.master)
//   irq_claim_o               one-hot claim pulse to the serviced source
module clint_vec
  import clint_vec_pkg::*;
#(
  parameter int unsigned NUM_IRQ       = 8,
  parameter int unsigned IRQ_BASE_CODE = 16,
  parameter int unsigned TIMER_IDX     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               div_started_i,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  input  logic [31:0]        csr_mstatus,
  input  logic               global_int_en_i,
  clint_vec_if.master        bus,
  output logic [NUM_IRQ-1:0] irq_claim_o
);

  state_e             state_q, state_d;
  arb_e               arb_s, kind_q, kind_d;
  logic [31:0]        epc_q, epc_d, epc_s;
  logic [31:0]        cause_q, cause_d, cause_s;
  logic [NUM_IRQ-1:0] win_oh_q, win_oh_d;
  logic               enc_valid_s;
  logic [IDX_W-1:0]   enc_idx_s;
  logic [NUM_IRQ-1:0] enc_oh_s;
  logic [30:0]        code_s;
  logic               is_exc_s;
  logic [31:0]        mtvec_base_s, vec_addr_s;

  logic               we_q, we_d, assert_q, assert_d;
  logic [31:0]        waddr_q, waddr_d, data_q, data_d, addr_q, addr_d;
  logic [NUM_IRQ-1:0] claim_q, claim_d;

  clint_vec_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .req_i    (irq_i),
    .en_i     (irq_en_i),
    .valid_o  (enc_valid_s),
    .idx_o    (enc_idx_s),
    .onehot_o (enc_oh_s)
  );

  assign is_exc_s = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign code_s   = (enc_idx_s == IDX_W'(TIMER_IDX)) ? CAUSE_MTIMER
                                                     : 31'(IRQ_BASE_CODE) + 31'(enc_idx_s);

  // Arbitration: exceptions beat interrupts; an exception behind a busy divider stalls everything.
  always_comb begin
    arb_s = ARB_NONE;
    if (state_q == ST_IDLE) begin
      if (is_exc_s) begin
        arb_s = div_started_i ? ARB_NONE : ARB_SYNC;
      end else if (enc_valid_s && global_int_en_i) begin
        arb_s = ARB_ASYNC;
      end else if (inst_i == INST_MRET) begin
        arb_s = ARB_MRET;
      end else begin
        arb_s = ARB_NONE;
      end
    end else begin
      arb_s = ARB_NONE;
    end
  end

  // Return address and cause captured when a trap is accepted.
  always_comb begin
    epc_s   = inst_addr_i;
    cause_s = 32'h0000_0000;
    if (jump_flag_i) begin
      epc_s = (arb_s == ARB_SYNC) ? (jump_addr_i - 32'd4) : jump_addr_i;
    end else if ((arb_s == ARB_ASYNC) && div_started_i) begin
      // Divider instruction was issued but not retired; restart it.
      epc_s = inst_addr_i - 32'd4;
    end else begin
      epc_s = inst_addr_i;
    end
    if (arb_s == ARB_SYNC) begin
      cause_s = (inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
    end else if (arb_s == ARB_ASYNC) begin
      cause_s = {1'b1, code_s};
    end else begin
      cause_s = 32'h0000_0000;
    end
  end

  // Next-state logic and latch of trap context on leaving IDLE.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    win_oh_d = win_oh_q;
    case (state_q)
      ST_IDLE: begin
        case (arb_s)
          ARB_SYNC, ARB_ASYNC: begin
            state_d  = ST_MEPC;
            kind_d   = arb_s;
            epc_d    = epc_s;
            cause_d  = cause_s;
            win_oh_d = (arb_s == ARB_ASYNC) ? enc_oh_s : '0;
          end
          ARB_MRET: begin
            state_d = ST_MRET_MSTATUS;
            kind_d  = ARB_MRET;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_MEPC:         state_d = ST_MSTATUS;
      ST_MSTATUS:      state_d = ST_MCAUSE;
      ST_MCAUSE:       state_d = ST_ASSERT;
      ST_ASSERT:       state_d = ST_IDLE;
      ST_MRET_MSTATUS: state_d = ST_MRET_ASSERT;
      ST_MRET_ASSERT:  state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  assign mtvec_base_s = {csr_mtvec[31:2], 2'b00};
  // Only interrupts are vectored; code is cause[30:0], shifted by 2 modulo 2^32.
  assign vec_addr_s = ((csr_mtvec[1:0] == INT_MODE_VECTORED) && (kind_d == ARB_ASYNC))
                    ? mtvec_base_s + {cause_d[29:0], 2'b00} : mtvec_base_s;

  // Outputs decoded from the next state so they are registered yet line up with the state.
  always_comb begin
    we_d     = 1'b0;
    waddr_d  = 32'h0000_0000;
    data_d   = 32'h0000_0000;
    assert_d = 1'b0;
    addr_d   = 32'h0000_0000;
    claim_d  = '0;
    case (state_d)
      ST_MEPC: begin
        we_d    = 1'b1;
        waddr_d = csr_waddr(CSR_MEPC);
        data_d  = epc_d;
      end
      ST_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = csr_waddr(CSR_MSTATUS);
        data_d  = mstatus_trap(csr_mstatus);
      end
      ST_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = csr_waddr(CSR_MCAUSE);
        data_d  = cause_d;
      end
      ST_ASSERT: begin
        assert_d = 1'b1;
        addr_d   = vec_addr_s;
        claim_d  = (kind_d == ARB_ASYNC) ? win_oh_d : '0;
      end
      ST_MRET_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = csr_waddr(CSR_MSTATUS);
        data_d  = mstatus_mret(csr_mstatus);
      end
      ST_MRET_ASSERT: begin
        assert_d = 1'b1;
        addr_d   = csr_mepc;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // State, trap context and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= ARB_NONE;
      epc_q    <= 32'h0000_0000;
      cause_q  <= 32'h0000_0000;
      win_oh_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= 32'h0000_0000;
      data_q   <= 32'h0000_0000;
      assert_q <= 1'b0;
      addr_q   <= 32'h0000_0000;
      claim_q  <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      win_oh_q <= win_oh_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      assert_q <= assert_d;
      addr_q   <= addr_d;
      claim_q  <= claim_d;
    end
  end

  // Hold must rise in the arbitration cycle itself, so it is combinational; gated by reset.
  assign bus.hold_flag_o  = rst & ((state_q != ST_IDLE) || (arb_s != ARB_NONE));
  assign bus.we_o         = we_q;
  assign bus.waddr_o      = waddr_q;
  assign bus.data_o       = data_q;
  assign bus.int_addr_o   = addr_q;
  assign bus.int_assert_o = assert_q;
  assign irq_claim_o      = claim_q;

endmodule
